// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: bus widths, default timing constants and the
// arbiter state encoding. Also used by ov5640_cfg.
package sccb_pkg;

  localparam int SCCB_ADDR_W      = 16;
  localparam int SCCB_DATA_W      = 8;
  localparam int SCCB_GAP_CYC     = 8;
  localparam int SCCB_TIMEOUT_CYC = 2048;
  localparam int SCCB_TO_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sccb_state_t;

  // Operands captured from the winning requester at grant time.
  typedef struct packed {
    logic                   wr;
    logic [SCCB_ADDR_W-1:0] addr;
    logic [SCCB_DATA_W-1:0] wdata;
  } sccb_op_t;

endpackage

// File: rtl/sccb_arbiter_if.sv
// Requester and i2c_ctrl signals of the SCCB arbiter. The arbiter takes the
// slave view; the requesters / i2c_ctrl side takes the master view.
interface sccb_arbiter_if;
  import sccb_pkg::*;

  logic                   req0;
  logic                   req0_wr;
  logic [SCCB_ADDR_W-1:0] req0_addr;
  logic [SCCB_DATA_W-1:0] req0_wdata;
  logic                   req0_done;
  logic                   req0_err;

  logic                   req1;
  logic                   req1_wr;
  logic [SCCB_ADDR_W-1:0] req1_addr;
  logic [SCCB_DATA_W-1:0] req1_wdata;
  logic                   req1_done;
  logic                   req1_err;

  logic [SCCB_DATA_W-1:0] rdata;
  logic [1:0]             grant;
  logic                   busy;

  logic                   i2c_start;
  logic                   i2c_wr_en;
  logic                   i2c_rd_en;
  logic [SCCB_ADDR_W-1:0] i2c_byte_addr;
  logic [SCCB_DATA_W-1:0] i2c_wr_data;
  logic                   i2c_end;
  logic [SCCB_DATA_W-1:0] i2c_rd_data;

  modport slave (
    input  req0, req0_wr, req0_addr, req0_wdata,
    input  req1, req1_wr, req1_addr, req1_wdata,
    input  i2c_end, i2c_rd_data,
    output req0_done, req0_err, req1_done, req1_err,
    output rdata, grant, busy,
    output i2c_start, i2c_wr_en, i2c_rd_en, i2c_byte_addr, i2c_wr_data
  );

  modport master (
    output req0, req0_wr, req0_addr, req0_wdata,
    output req1, req1_wr, req1_addr, req1_wdata,
    output i2c_end, i2c_rd_data,
    input  req0_done, req0_err, req1_done, req1_err,
    input  rdata, grant, busy,
    input  i2c_start, i2c_wr_en, i2c_rd_en, i2c_byte_addr, i2c_wr_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way pick: round robin against last_grant, or fixed priority to port 0.
// Purely combinational; the last-grant register lives in the parent.
module rr_arb2 #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,   // 1 = port 1 owned the previous grant
  output logic [1:0] grant
);

  // NOTE: grant gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      if (PRIORITY_MODE == 1 || last_grant)
        grant = 2'b01;
      else
        grant = 2'b10;
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one i2c_ctrl SCCB master between the boot sequencer (port 0) and
// the runtime register port (port 1), with a post-completion gap and timeout.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int GAP_CYC       = SCCB_GAP_CYC,
  parameter int TIMEOUT_CYC   = SCCB_TIMEOUT_CYC,
  parameter int TO_W          = SCCB_TO_W
) (
  input logic           sys_clk,
  input logic           sys_rst,
  sccb_arbiter_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_CYC - 1);

  sccb_state_t     state;
  logic [TO_W-1:0] cnt;
  logic            last_grant;
  logic [1:0]      pick;
  sccb_op_t        win_op;

  rr_arb2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_pick (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    win_op = '{wr: bus.req1_wr, addr: bus.req1_addr, wdata: bus.req1_wdata};
    if (pick[0])
      win_op = '{wr: bus.req0_wr, addr: bus.req0_addr, wdata: bus.req0_wdata};
  end

  // NOTE: every register here uses <= so all branches see the pre-edge
  // values of state, cnt and grant regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      last_grant        <= 1'b1;
      bus.grant         <= '0;
      bus.busy          <= 1'b0;
      bus.i2c_start     <= 1'b0;
      bus.i2c_wr_en     <= 1'b0;
      bus.i2c_rd_en     <= 1'b0;
      bus.i2c_byte_addr <= '0;
      bus.i2c_wr_data   <= '0;
      bus.rdata         <= '0;
      bus.req0_done     <= 1'b0;
      bus.req0_err      <= 1'b0;
      bus.req1_done     <= 1'b0;
      bus.req1_err      <= 1'b0;
    end else begin
      bus.i2c_start <= 1'b0;
      bus.req0_done <= 1'b0;
      bus.req0_err  <= 1'b0;
      bus.req1_done <= 1'b0;
      bus.req1_err  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (|pick) begin
            bus.grant         <= pick;
            last_grant        <= pick[1];
            bus.i2c_byte_addr <= win_op.addr;
            bus.i2c_wr_data   <= win_op.wdata;
            bus.i2c_wr_en     <= win_op.wr;
            bus.i2c_rd_en     <= ~win_op.wr;
            bus.i2c_start     <= 1'b1;
            bus.busy          <= 1'b1;
            state             <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A completion landing on the expiry cycle counts as success.
          if (bus.i2c_end || cnt == TO_LAST) begin
            bus.rdata     <= (bus.i2c_end && bus.i2c_rd_en) ? bus.i2c_rd_data : '0;
            bus.req0_done <= bus.grant[0];
            bus.req1_done <= bus.grant[1];
            bus.req0_err  <= bus.grant[0] & ~bus.i2c_end;
            bus.req1_err  <= bus.grant[1] & ~bus.i2c_end;
            bus.grant     <= '0;
            bus.i2c_wr_en <= 1'b0;
            bus.i2c_rd_en <= 1'b0;
            cnt           <= '0;
            state         <= ST_GAP;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter: vector table of single transactions plus
// hand-written timeout, reset and contention sequences.
module tb_sccb_arbiter;

  localparam int GAP = 8;
  localparam int TMO = 2048;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  always #5 sys_clk = ~sys_clk;

  sccb_arbiter_if bus0 ();
  sccb_arbiter_if bus1 ();

  sccb_arbiter #(.PRIORITY_MODE(0), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .TO_W(12)) dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus0)
  );

  sccb_arbiter #(.PRIORITY_MODE(1), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .TO_W(12)) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus1)
  );

  typedef struct {
    int          port;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          dly;
    logic [7:0]  rd;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [5];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic wait_idle0(input string tag);
    int k = 0;
    while (bus0.busy && k < 100) begin
      tick();
      k++;
    end
    check({tag, " back to idle"}, bus0.busy, 0);
  endtask

  // One transaction on dut0: request, i2c_ctrl model answers after v.dly cycles.
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] g;
    int         early;
    g     = (v.port == 0) ? 2'b01 : 2'b10;
    early = 0;
    if (v.port == 0) begin
      bus0.req0 = 1'b1; bus0.req0_wr = v.wr; bus0.req0_addr = v.addr; bus0.req0_wdata = v.wdata;
    end else begin
      bus0.req1 = 1'b1; bus0.req1_wr = v.wr; bus0.req1_addr = v.addr; bus0.req1_wdata = v.wdata;
    end
    tick();
    check({tag, " start"}, bus0.i2c_start, 1);
    check({tag, " grant"}, bus0.grant, g);
    check({tag, " addr"}, bus0.i2c_byte_addr, v.addr);
    check({tag, " wdata"}, bus0.i2c_wr_data, v.wdata);
    check({tag, " wr_en"}, bus0.i2c_wr_en, v.wr);
    check({tag, " rd_en"}, bus0.i2c_rd_en, !v.wr);
    // Operands changing after grant must not reach i2c_ctrl.
    bus0.req0_addr = ~v.addr; bus0.req0_wdata = ~v.wdata;
    bus0.req1_addr = ~v.addr; bus0.req1_wdata = ~v.wdata;
    for (int k = 0; k < v.dly; k++) begin
      tick();
      if (bus0.req0_done || bus0.req1_done) early++;
    end
    check({tag, " no early done"}, early, 0);
    check({tag, " addr held"}, bus0.i2c_byte_addr, v.addr);
    check({tag, " wr_en held"}, bus0.i2c_wr_en, v.wr);
    bus0.i2c_end     = 1'b1;
    bus0.i2c_rd_data = v.rd;
    tick();
    bus0.i2c_end = 1'b0;
    bus0.req0    = 1'b0;
    bus0.req1    = 1'b0;
    check({tag, " done"}, {bus0.req1_done, bus0.req0_done}, g);
    check({tag, " err"}, {bus0.req1_err, bus0.req0_err}, 0);
    check({tag, " rdata"}, bus0.rdata, v.exp_rdata);
    check({tag, " grant cleared"}, bus0.grant, 0);
    check({tag, " busy in gap"}, bus0.busy, 1);
    check({tag, " enables cleared"}, {bus0.i2c_wr_en, bus0.i2c_rd_en}, 0);
    tick();
    check({tag, " done one cycle"}, {bus0.req1_done, bus0.req0_done}, 0);
    wait_idle0(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 16'h3008, 8'h82, 150, 8'hAA, 8'h00};
    vecs[1] = '{1, 1'b0, 16'h300A, 8'h00, 20,  8'h56, 8'h56};
    vecs[2] = '{0, 1'b0, 16'h3820, 8'h00, 1,   8'h3C, 8'h3C};
    vecs[3] = '{1, 1'b1, 16'h5000, 8'hA5, 5,   8'h77, 8'h00};
    vecs[4] = '{0, 1'b0, 16'h3034, 8'h00, TMO, 8'h9E, 8'h9E};

    bus0.req0 = 0; bus0.req0_wr = 0; bus0.req0_addr = 0; bus0.req0_wdata = 0;
    bus0.req1 = 0; bus0.req1_wr = 0; bus0.req1_addr = 0; bus0.req1_wdata = 0;
    bus0.i2c_end = 0; bus0.i2c_rd_data = 0;
    bus1.req0 = 0; bus1.req0_wr = 0; bus1.req0_addr = 0; bus1.req0_wdata = 0;
    bus1.req1 = 0; bus1.req1_wr = 0; bus1.req1_addr = 0; bus1.req1_wdata = 0;
    bus1.i2c_end = 0; bus1.i2c_rd_data = 0;

    // Reset state
    repeat (2) tick();
    check("reset outputs", |{bus0.busy, bus0.grant, bus0.i2c_start, bus0.i2c_wr_en,
                             bus0.i2c_rd_en, bus0.i2c_byte_addr, bus0.i2c_wr_data, bus0.rdata,
                             bus0.req0_done, bus0.req0_err, bus0.req1_done, bus0.req1_err}, 0);
    sys_rst = 1'b0;
    tick();
    check("idle after reset busy", bus0.busy, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout: i2c_end withheld, then a late i2c_end during GAP.
    begin
      int k = 0;
      int seen = 0;
      bus0.req0 = 1; bus0.req0_wr = 1; bus0.req0_addr = 16'h3103; bus0.req0_wdata = 8'h11;
      tick();
      check("tmo start", bus0.i2c_start, 1);
      while (!bus0.req0_done && k < TMO + 20) begin
        tick();
        k++;
      end
      bus0.req0 = 0;
      check("tmo latency", k, TMO + 1);
      check("tmo err", bus0.req0_err, 1);
      check("tmo rdata", bus0.rdata, 0);
      check("tmo port1 quiet", {bus0.req1_done, bus0.req1_err}, 0);
      tick();
      bus0.i2c_end = 1; bus0.i2c_rd_data = 8'hEE;
      tick();
      bus0.i2c_end = 0;
      for (int j = 0; j < GAP + 3; j++) begin
        if (bus0.req0_done || bus0.req1_done) seen++;
        tick();
      end
      check("stale end ignored", seen, 0);
      check("tmo back to idle", bus0.busy, 0);
    end

    // Asynchronous reset in the middle of WAIT.
    begin
      int seen = 0;
      bus0.req1 = 1; bus0.req1_wr = 0; bus0.req1_addr = 16'h4300; bus0.req1_wdata = 0;
      tick();
      check("rst start", bus0.i2c_start, 1);
      repeat (3) tick();
      check("rst busy before", bus0.busy, 1);
      #2 sys_rst = 1'b1;
      #1;
      check("rst async outputs", |{bus0.busy, bus0.grant, bus0.i2c_start, bus0.i2c_wr_en,
                                   bus0.i2c_rd_en, bus0.i2c_byte_addr, bus0.rdata,
                                   bus0.req0_done, bus0.req1_done}, 0);
      bus0.req1 = 0;
      tick();
      sys_rst = 1'b0;
      bus0.i2c_end = 1; bus0.i2c_rd_data = 8'h12;
      tick();
      bus0.i2c_end = 0;
      for (int j = 0; j < 4; j++) begin
        if (bus0.req0_done || bus0.req1_done || bus0.busy) seen++;
        tick();
      end
      check("rst no done", seen, 0);
      run_vec(vecs[1], "after rst");
    end

    // Round robin: both held, grants alternate with fixed spacing.
    begin
      int n = 0, cyc = 0, last = -1, end_at = -1, k = 0;
      logic [1:0] order [4];
      bus0.req0 = 1; bus0.req0_wr = 1; bus0.req0_addr = 16'h0100; bus0.req0_wdata = 8'h01;
      bus0.req1 = 1; bus0.req1_wr = 1; bus0.req1_addr = 16'h0200; bus0.req1_wdata = 8'h02;
      while (n < 4 && cyc < 500) begin
        tick();
        cyc++;
        bus0.i2c_end = (cyc == end_at);
        if (bus0.i2c_start) begin
          order[n] = bus0.grant;
          if (last >= 0) check($sformatf("rr spacing %0d", n), cyc - last, GAP + 5);
          last = cyc;
          end_at = cyc + 3;
          n++;
        end
      end
      bus0.req0 = 0;
      bus0.req1 = 0;
      check("rr grant count", n, 4);
      check("rr order0", order[0], 2'b01);
      check("rr order1", order[1], 2'b10);
      check("rr order2", order[2], 2'b01);
      check("rr order3", order[3], 2'b10);
      while (bus0.busy && k < 100) begin
        tick();
        cyc++;
        k++;
        bus0.i2c_end = (cyc == end_at);
      end
      bus0.i2c_end = 0;
      check("rr back to idle", bus0.busy, 0);
    end

    // Fixed priority: port 0 keeps winning until it drops its request.
    begin
      int n = 0, cyc = 0, end_at = -1, k = 0, done0 = 0;
      logic [1:0] order [4];
      bus1.req0 = 1; bus1.req0_wr = 1; bus1.req0_addr = 16'h0300; bus1.req0_wdata = 8'h03;
      bus1.req1 = 1; bus1.req1_wr = 1; bus1.req1_addr = 16'h0400; bus1.req1_wdata = 8'h04;
      while (n < 4 && cyc < 500) begin
        tick();
        cyc++;
        bus1.i2c_end = (cyc == end_at);
        if (bus1.req0_done) done0++;
        if (bus1.i2c_start) begin
          order[n] = bus1.grant;
          end_at = cyc + 3;
          n++;
          if (n == 3) bus1.req0 = 0;
        end
      end
      bus1.req1 = 0;
      check("fp grant count", n, 4);
      check("fp order0", order[0], 2'b01);
      check("fp order1", order[1], 2'b01);
      check("fp order2", order[2], 2'b01);
      check("fp order3", order[3], 2'b10);
      check("fp dropped req done", done0, 3);
      while (bus1.busy && k < 100) begin
        tick();
        cyc++;
        k++;
        bus1.i2c_end = (cyc == end_at);
      end
      bus1.i2c_end = 0;
      check("fp back to idle", bus1.busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
